// File: rtl/wb_regfile_stage_if.sv
// EX/MEM -> writeback bus: the instruction presented by ex_mem plus the
// squash control. The producer side is the master, and the writeback stage is the slave.
interface wb_regfile_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              ex_mem_valid;
    logic              ex_mem_wen;
    logic [ADDR_W-1:0] ex_mem_portC;
    logic [DATA_W-1:0] ex_mem_ALUout;
    logic              flush;

    modport master (
        output ex_mem_valid,
        output ex_mem_wen,
        output ex_mem_portC,
        output ex_mem_ALUout,
        output flush
    );

    modport slave (
        input ex_mem_valid,
        input ex_mem_wen,
        input ex_mem_portC,
        input ex_mem_ALUout,
        input flush
    );
endinterface

// File: rtl/wb_regfile_stage.sv
// Writeback stage and architectural register file.
// The stage captures EX/MEM into a MEM/WB register and commits that entry to the
// register file on the following edge. It serves two decode read ports, with
// write-through bypass of the MEM/WB entry. It also drives the MEM/WB->EX
// forwarding compares and counts retired instructions.
// A debug port can preload registers. When a debug write collides with a
// pipeline commit, the pipeline write wins and the debug write is dropped and flagged.
module wb_regfile_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,

    wb_regfile_stage_if.slave ex_mem,

    input  logic [ADDR_W-1:0] portA_addr,
    input  logic [ADDR_W-1:0] portB_addr,
    output logic [DATA_W-1:0] dataA,
    output logic [DATA_W-1:0] dataB,

    input  logic [ADDR_W-1:0] ex_srcA,
    input  logic [ADDR_W-1:0] ex_srcB,
    output logic              fwd_matchA,
    output logic              fwd_matchB,
    output logic [DATA_W-1:0] fwd_data,

    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              dbg_conflict,

    output logic [CNT_W-1:0]  retired_count
);

    // MEM/WB pipeline register
    logic              mem_wb_valid_q, mem_wb_valid_d;
    logic              mem_wb_wen_q,   mem_wb_wen_d;
    logic [ADDR_W-1:0] mem_wb_portC_q, mem_wb_portC_d;
    logic [DATA_W-1:0] mem_wb_data_q,  mem_wb_data_d;

    // Architectural state
    logic [DATA_W-1:0] regs_q [NREG];
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              dbg_conflict_q, dbg_conflict_d;

    // Single register-file write port, shared by the pipeline and debug
    logic              commit;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // A commit needs a writing MEM/WB entry that does not target r0.
    assign commit = mem_wb_wen_q && (mem_wb_portC_q != '0);

    // Next-state for the MEM/WB capture; a flushed or invalid slot never writes
    always_comb begin
        mem_wb_valid_d = ex_mem.ex_mem_valid & ~ex_mem.flush;
        mem_wb_wen_d   = ex_mem.ex_mem_wen & ex_mem.ex_mem_valid & ~ex_mem.flush;
        mem_wb_portC_d = ex_mem.ex_mem_portC;
        mem_wb_data_d  = ex_mem.ex_mem_ALUout;
    end

    // MEM/WB register, cleared by reset so an in-flight entry is discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wb_valid_q <= 1'b0;
            mem_wb_wen_q   <= 1'b0;
            mem_wb_portC_q <= '0;
            mem_wb_data_q  <= '0;
        end else begin
            mem_wb_valid_q <= mem_wb_valid_d;
            mem_wb_wen_q   <= mem_wb_wen_d;
            mem_wb_portC_q <= mem_wb_portC_d;
            mem_wb_data_q  <= mem_wb_data_d;
        end
    end

    // Write-port arbitration: the pipeline commit has priority, and r0 is never written
    always_comb begin
        wr_en          = 1'b0;
        wr_addr        = '0;
        wr_data        = '0;
        dbg_conflict_d = 1'b0;
        if (commit) begin
            wr_en          = 1'b1;
            wr_addr        = mem_wb_portC_q;
            wr_data        = mem_wb_data_q;
            dbg_conflict_d = dbg_we;
        end else if (dbg_we && (dbg_addr != '0)) begin
            wr_en   = 1'b1;
            wr_addr = dbg_addr;
            wr_data = dbg_data;
        end
    end

    // Register file storage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Flag the one-cycle pulse for a dropped debug write
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_conflict_q <= 1'b0;
        end else begin
            dbg_conflict_q <= dbg_conflict_d;
        end
    end

    // Count every valid MEM/WB slot, writing or not; the count wraps silently
    always_comb begin
        retired_d = retired_q + CNT_W'(mem_wb_valid_q);
    end

    // Retired-instruction counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    // Decode read ports: r0 reads as zero, the MEM/WB entry bypasses the array.
    // Debug writes never bypass, because they only land in the array.
    always_comb begin
        if (portA_addr == '0) begin
            dataA = '0;
        end else if (mem_wb_wen_q && (mem_wb_portC_q == portA_addr)) begin
            dataA = mem_wb_data_q;
        end else begin
            dataA = regs_q[portA_addr];
        end

        if (portB_addr == '0) begin
            dataB = '0;
        end else if (mem_wb_wen_q && (mem_wb_portC_q == portB_addr)) begin
            dataB = mem_wb_data_q;
        end else begin
            dataB = regs_q[portB_addr];
        end
    end

    // MEM/WB->EX forwarding compares; both operands may match the same entry
    always_comb begin
        fwd_matchA = commit && (mem_wb_portC_q == ex_srcA);
        fwd_matchB = commit && (mem_wb_portC_q == ex_srcB);
        fwd_data   = mem_wb_data_q;
    end

    assign dbg_conflict  = dbg_conflict_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed test of the writeback stage / register file.
module tb_wb_regfile_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] portA_addr, portB_addr;
    logic [DATA_W-1:0] dataA, dataB;
    logic [ADDR_W-1:0] ex_srcA, ex_srcB;
    logic              fwd_matchA, fwd_matchB;
    logic [DATA_W-1:0] fwd_data;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              dbg_conflict;
    logic [CNT_W-1:0]  retired_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ret  = 0;

    wb_regfile_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) exm ();

    wb_regfile_stage #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_mem       (exm.slave),
        .portA_addr   (portA_addr),
        .portB_addr   (portB_addr),
        .dataA        (dataA),
        .dataB        (dataB),
        .ex_srcA      (ex_srcA),
        .ex_srcB      (ex_srcB),
        .fwd_matchA   (fwd_matchA),
        .fwd_matchB   (fwd_matchB),
        .fwd_data     (fwd_data),
        .dbg_we       (dbg_we),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data),
        .dbg_conflict (dbg_conflict),
        .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic w, input logic [ADDR_W-1:0] pc,
                            input logic [DATA_W-1:0] d, input logic fl);
        exm.ex_mem_valid  = v;
        exm.ex_mem_wen    = w;
        exm.ex_mem_portC  = pc;
        exm.ex_mem_ALUout = d;
        exm.flush         = fl;
    endtask

    task automatic idle_ex();
        drive_ex(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        portA_addr = 5'd5; ex_srcA = 5'd3; ex_srcB = 5'd0;
        #1;
        n_checks++; if (retired_count !== 16'd0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", retired_count); end
        n_checks++; if (dbg_conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict: got %b want 0", dbg_conflict); end
        n_checks++; if (fwd_matchA !== 1'b0) begin n_fail++; $display("FAIL reset_fwdA: got %b want 0", fwd_matchA); end
        n_checks++; if (fwd_data !== 32'd0) begin n_fail++; $display("FAIL reset_fwd_data: got %h want 0", fwd_data); end
        n_checks++; if (dataA !== 32'd0) begin n_fail++; $display("FAIL reset_r5: got %h want 0", dataA); end
    endtask

    // Capture, forward and bypass while the instruction is in MEM/WB, then commit.
    task automatic test_capture_bypass();
        drive_ex(1'b1, 1'b1, 5'd3, 32'd100, 1'b0);
        ex_srcA = 5'd3; ex_srcB = 5'd4;
        portA_addr = 5'd3; portB_addr = 5'd3;
        tick();
        idle_ex();
        #1;
        n_checks++; if (fwd_data !== 32'd100) begin n_fail++; $display("FAIL cap_fwd_data: got %0d want 100", fwd_data); end
        n_checks++; if (fwd_matchA !== 1'b1) begin n_fail++; $display("FAIL cap_fwdA: got %b want 1", fwd_matchA); end
        n_checks++; if (fwd_matchB !== 1'b0) begin n_fail++; $display("FAIL cap_fwdB: got %b want 0", fwd_matchB); end
        n_checks++; if (dataA !== 32'd100) begin n_fail++; $display("FAIL byp_dataA: got %0d want 100", dataA); end
        n_checks++; if (dataB !== 32'd100) begin n_fail++; $display("FAIL byp_dataB: got %0d want 100", dataB); end
        n_checks++; if (retired_count !== 16'd0) begin n_fail++; $display("FAIL cap_retired_early: got %0d want 0", retired_count); end
        tick();
        exp_ret = 1;
        n_checks++; if (dataA !== 32'd100) begin n_fail++; $display("FAIL commit_r3: got %0d want 100", dataA); end
        n_checks++; if (fwd_matchA !== 1'b0) begin n_fail++; $display("FAIL commit_fwdA_idle: got %b want 0", fwd_matchA); end
        n_checks++; if (fwd_data !== 32'd0) begin n_fail++; $display("FAIL commit_fwd_data_idle: got %h want 0", fwd_data); end
        n_checks++; if (retired_count !== 16'(exp_ret)) begin n_fail++; $display("FAIL commit_retired: got %0d want %0d", retired_count, exp_ret); end
    endtask

    task automatic test_r0_and_dbg();
        drive_ex(1'b1, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0);
        ex_srcA = 5'd0; portA_addr = 5'd0;
        tick();
        idle_ex();
        #1;
        n_checks++; if (fwd_matchA !== 1'b0) begin n_fail++; $display("FAIL r0_fwdA: got %b want 0", fwd_matchA); end
        n_checks++; if (dataA !== 32'd0) begin n_fail++; $display("FAIL r0_bypass: got %h want 0", dataA); end
        n_checks++; if (fwd_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL r0_fwd_data: got %h want deadbeef", fwd_data); end
        tick();
        exp_ret++;
        dbg_we = 1'b1; dbg_addr = 5'd0; dbg_data = 32'h1234;
        tick();
        dbg_we = 1'b0;
        #1;
        n_checks++; if (dataA !== 32'd0) begin n_fail++; $display("FAIL r0_after: got %h want 0", dataA); end
        n_checks++; if (dbg_conflict !== 1'b0) begin n_fail++; $display("FAIL r0_dbg_conflict: got %b want 0", dbg_conflict); end
        dbg_we = 1'b1; dbg_addr = 5'd7; dbg_data = 32'hA5A5;
        portA_addr = 5'd7;
        #1;
        n_checks++; if (dataA !== 32'd0) begin n_fail++; $display("FAIL dbg_no_bypass: got %h want 0", dataA); end
        tick();
        dbg_we = 1'b0;
        #1;
        n_checks++; if (dataA !== 32'hA5A5) begin n_fail++; $display("FAIL dbg_write_r7: got %h want a5a5", dataA); end
        n_checks++; if (retired_count !== 16'(exp_ret)) begin n_fail++; $display("FAIL r0_retired: got %0d want %0d", retired_count, exp_ret); end
    endtask

    task automatic test_flush();
        drive_ex(1'b1, 1'b1, 5'd8, 32'h55, 1'b1);
        ex_srcA = 5'd8; portA_addr = 5'd8;
        tick();
        idle_ex();
        #1;
        n_checks++; if (fwd_matchA !== 1'b0) begin n_fail++; $display("FAIL flush_fwdA: got %b want 0", fwd_matchA); end
        n_checks++; if (dataA !== 32'd0) begin n_fail++; $display("FAIL flush_bypass: got %h want 0", dataA); end
        tick();
        n_checks++; if (dataA !== 32'd0) begin n_fail++; $display("FAIL flush_r8: got %h want 0", dataA); end
        n_checks++; if (retired_count !== 16'(exp_ret)) begin n_fail++; $display("FAIL flush_retired: got %0d want %0d", retired_count, exp_ret); end
    endtask

    task automatic test_conflict();
        drive_ex(1'b1, 1'b1, 5'd5, 32'h1111, 1'b0);
        tick();
        idle_ex();
        dbg_we = 1'b1; dbg_addr = 5'd6; dbg_data = 32'd7;
        tick();
        dbg_we = 1'b0;
        exp_ret++;
        portA_addr = 5'd5; portB_addr = 5'd6;
        #1;
        n_checks++; if (dbg_conflict !== 1'b1) begin n_fail++; $display("FAIL conflict_pulse: got %b want 1", dbg_conflict); end
        n_checks++; if (dataA !== 32'h1111) begin n_fail++; $display("FAIL conflict_r5: got %h want 1111", dataA); end
        n_checks++; if (dataB !== 32'd0) begin n_fail++; $display("FAIL conflict_r6: got %h want 0", dataB); end
        tick();
        n_checks++; if (dbg_conflict !== 1'b0) begin n_fail++; $display("FAIL conflict_one_cycle: got %b want 0", dbg_conflict); end
        n_checks++; if (retired_count !== 16'(exp_ret)) begin n_fail++; $display("FAIL conflict_retired: got %0d want %0d", retired_count, exp_ret); end
    endtask

    task automatic test_back_to_back();
        portA_addr = 5'd9; ex_srcA = 5'd9; ex_srcB = 5'd9;
        drive_ex(1'b1, 1'b1, 5'd9, 32'd1, 1'b0);
        tick();
        drive_ex(1'b1, 1'b1, 5'd9, 32'd2, 1'b0);
        #1;
        n_checks++; if (dataA !== 32'd1) begin n_fail++; $display("FAIL b2b_first_bypass: got %0d want 1", dataA); end
        n_checks++; if ((fwd_matchA !== 1'b1) || (fwd_matchB !== 1'b1)) begin n_fail++; $display("FAIL b2b_both_fwd: got %b%b want 11", fwd_matchA, fwd_matchB); end
        tick();
        idle_ex();
        #1;
        n_checks++; if (dataA !== 32'd2) begin n_fail++; $display("FAIL b2b_youngest_bypass: got %0d want 2", dataA); end
        tick();
        exp_ret += 2;
        n_checks++; if (dataA !== 32'd2) begin n_fail++; $display("FAIL b2b_final_r9: got %0d want 2", dataA); end
        n_checks++; if (retired_count !== 16'(exp_ret)) begin n_fail++; $display("FAIL b2b_retired: got %0d want %0d", retired_count, exp_ret); end
    endtask

    task automatic test_reset_mid();
        portA_addr = 5'd4; portB_addr = 5'd9; ex_srcA = 5'd4;
        drive_ex(1'b1, 1'b1, 5'd4, 32'd55, 1'b0);
        tick();
        idle_ex();
        #1;
        n_checks++; if (fwd_matchA !== 1'b1) begin n_fail++; $display("FAIL mid_inflight: got %b want 1", fwd_matchA); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ret = 0;
        #1;
        n_checks++; if (dataA !== 32'd0) begin n_fail++; $display("FAIL mid_r4_bypass: got %0d want 0", dataA); end
        n_checks++; if (fwd_matchA !== 1'b0) begin n_fail++; $display("FAIL mid_fwdA: got %b want 0", fwd_matchA); end
        n_checks++; if (dataB !== 32'd0) begin n_fail++; $display("FAIL mid_r9_cleared: got %0d want 0", dataB); end
        tick();
        n_checks++; if (dataA !== 32'd0) begin n_fail++; $display("FAIL mid_r4: got %0d want 0", dataA); end
        n_checks++; if (retired_count !== 16'd0) begin n_fail++; $display("FAIL mid_retired: got %0d want 0", retired_count); end
    endtask

    task automatic test_wrap();
        dbg_we = 1'b1; dbg_addr = 5'd10; dbg_data = 32'hCAFE;
        tick();
        dbg_we = 1'b0;
        portA_addr = 5'd10; ex_srcA = 5'd10;
        drive_ex(1'b1, 1'b0, 5'd10, 32'hFFFF, 1'b0);
        repeat (65536) tick();
        n_checks++; if (retired_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_near: got %0d want 65535", retired_count); end
        n_checks++; if (fwd_matchA !== 1'b0) begin n_fail++; $display("FAIL wrap_fwdA: got %b want 0", fwd_matchA); end
        idle_ex();
        tick();
        n_checks++; if (retired_count !== 16'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d want 0", retired_count); end
        n_checks++; if (dataA !== 32'hCAFE) begin n_fail++; $display("FAIL wrap_r10: got %h want cafe", dataA); end
    endtask

    initial begin
        rst = 1'b0;
        idle_ex();
        portA_addr = '0; portB_addr = '0;
        ex_srcA = '0; ex_srcB = '0;
        dbg_we = 1'b0; dbg_addr = '0; dbg_data = '0;
        test_reset();
        test_capture_bypass();
        test_r0_and_dbg();
        test_flush();
        test_conflict();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
